// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if
// Instruction-memory request/response bus between the fetch stage and the
// instruction memory.
//   imem_req   : fetch stage requests a word at imem_addr
//   imem_addr  : word address, held stable until imem_ready=1
//   imem_rdata : instruction word, valid in the cycle imem_ready=1
//   imem_ready : transaction completes this cycle (zero-wait allowed)
// Modports: master = fetch unit, slave = instruction memory.
interface pc_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ready
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit
// Fetch stage of the pipelined MIPS core. Owns the PC, issues instruction
// fetches over a req/ready bus, and loads the IF/ID pipeline register.
// Handles ID stalls (with a one-entry hold buffer for a fetch that lands
// while ID is stalled) and redirects (no delay slot: the instruction in IF
// is squashed, including one still in flight on the memory bus).
// Ports:
//   clk, reset        : clock (rising edge), synchronous active-high reset
//   NPC, redirect     : redirect target and strobe from ID next-PC logic
//   stall             : hazard unit request to hold PC and IF/ID
//   PC, PC_plus_4     : current fetch PC and its sequential successor
//   imem_bus          : instruction-memory bus (master side)
//   IR_D, PC_D, PC_plus_4_D, valid_D : IF/ID pipeline register
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            NPC,
  input  logic                   redirect,
  input  logic                   stall,
  output logic [31:0]            PC,
  output logic [31:0]            PC_plus_4,
  pc_fetch_unit_if.master        imem_bus,
  output logic [31:0]            IR_D,
  output logic [31:0]            PC_D,
  output logic [31:0]            PC_plus_4_D,
  output logic                   valid_D
);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    SQUASH = 2'd2
  } state_t;

  state_t      state_reg, state_next;
  logic [31:0] pc_reg, pc_next;
  logic [31:0] ir_d_reg, ir_d_next;
  logic [31:0] pc_d_reg, pc_d_next;
  logic [31:0] pc_plus_4_d_reg, pc_plus_4_d_next;
  logic        valid_d_reg, valid_d_next;
  logic [31:0] hold_instr_reg, hold_instr_next;
  logic [31:0] hold_pc_reg, hold_pc_next;
  logic [31:0] stale_addr_reg, stale_addr_next;

  logic [31:0] pc_inc;
  logic [31:0] npc_aligned;

  assign pc_inc      = pc_reg + 32'd4;
  assign npc_aligned = NPC & ~32'd3;

  always_comb begin
    state_next       = state_reg;
    pc_next          = pc_reg;
    ir_d_next        = ir_d_reg;
    pc_d_next        = pc_d_reg;
    pc_plus_4_d_next = pc_plus_4_d_reg;
    valid_d_next     = valid_d_reg;
    hold_instr_next  = hold_instr_reg;
    hold_pc_next     = hold_pc_reg;
    stale_addr_next  = stale_addr_reg;
    imem_bus.imem_req  = 1'b0;
    imem_bus.imem_addr = pc_reg;

    case (state_reg)
      FETCH: begin
        imem_bus.imem_req  = 1'b1;
        imem_bus.imem_addr = pc_reg;
        if (imem_bus.imem_ready) begin
          if (redirect) begin
            pc_next      = npc_aligned;
            valid_d_next = 1'b0;
          end else if (stall) begin
            // ID cannot accept it yet: park the word and stop requesting.
            hold_instr_next = imem_bus.imem_rdata;
            hold_pc_next    = pc_reg;
            state_next      = HOLD;
          end else begin
            ir_d_next        = imem_bus.imem_rdata;
            pc_d_next        = pc_reg;
            pc_plus_4_d_next = pc_inc;
            valid_d_next     = 1'b1;
            pc_next          = pc_inc;
          end
        end else begin
          if (redirect) begin
            // The request must stay on the bus until it completes, so
            // remember its address and drain it in SQUASH.
            stale_addr_next = pc_reg;
            pc_next         = npc_aligned;
            valid_d_next    = 1'b0;
            state_next      = SQUASH;
          end else if (!stall) begin
            valid_d_next = 1'b0;
          end
        end
      end

      HOLD: begin
        if (redirect) begin
          pc_next      = npc_aligned;
          valid_d_next = 1'b0;
          state_next   = FETCH;
        end else if (!stall) begin
          ir_d_next        = hold_instr_reg;
          pc_d_next        = hold_pc_reg;
          pc_plus_4_d_next = hold_pc_reg + 32'd4;
          valid_d_next     = 1'b1;
          pc_next          = pc_inc;
          state_next       = FETCH;
        end
      end

      SQUASH: begin
        imem_bus.imem_req  = 1'b1;
        imem_bus.imem_addr = stale_addr_reg;
        if (redirect) begin
          // Latest target wins; the stale transaction is still drained.
          pc_next      = npc_aligned;
          valid_d_next = 1'b0;
        end else begin
          if (imem_bus.imem_ready) begin
            state_next = FETCH;
          end
          if (!stall) begin
            valid_d_next = 1'b0;
          end
        end
      end

      default: begin
        state_next = FETCH;
      end
    endcase

    if (reset) begin
      imem_bus.imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= FETCH;
      pc_reg          <= RESET_PC;
      ir_d_reg        <= NOP_INSTR;
      pc_d_reg        <= 32'd0;
      pc_plus_4_d_reg <= 32'd0;
      valid_d_reg     <= 1'b0;
      hold_instr_reg  <= 32'd0;
      hold_pc_reg     <= 32'd0;
      stale_addr_reg  <= 32'd0;
    end else begin
      state_reg       <= state_next;
      pc_reg          <= pc_next;
      ir_d_reg        <= ir_d_next;
      pc_d_reg        <= pc_d_next;
      pc_plus_4_d_reg <= pc_plus_4_d_next;
      valid_d_reg     <= valid_d_next;
      hold_instr_reg  <= hold_instr_next;
      hold_pc_reg     <= hold_pc_next;
      stale_addr_reg  <= stale_addr_next;
    end
  end

  assign PC          = pc_reg;
  assign PC_plus_4   = pc_inc;
  assign IR_D        = ir_d_reg;
  assign PC_D        = pc_d_reg;
  assign PC_plus_4_D = pc_plus_4_d_reg;
  assign valid_D     = valid_d_reg;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit
// Directed scenarios followed by randomized traffic for pc_fetch_unit. A
// transaction-level reference model (flags for "word parked for ID" and
// "in-flight request is stale") predicts the bus and IF/ID contents.
module tb_pc_fetch_unit;
  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] NPC;
  logic        redirect;
  logic        stall;
  logic [31:0] PC, PC_plus_4, IR_D, PC_D, PC_plus_4_D;
  logic        valid_D;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_PC  (RESET_PC),
    .NOP_INSTR (NOP_INSTR)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .NPC         (NPC),
    .redirect    (redirect),
    .stall       (stall),
    .PC          (PC),
    .PC_plus_4   (PC_plus_4),
    .imem_bus    (bus),
    .IR_D        (IR_D),
    .PC_D        (PC_D),
    .PC_plus_4_D (PC_plus_4_D),
    .valid_D     (valid_D)
  );

  // Reference model state.
  logic        m_known;
  logic [31:0] m_pc;
  logic        m_parked;       // a completed word is waiting for ID
  logic [31:0] m_park_instr;
  logic [31:0] m_park_pc;
  logic        m_stale_busy;   // the in-flight request belongs to an old path
  logic [31:0] m_stale_addr;
  logic [31:0] m_ir, m_pcd, m_pc4d;
  logic        m_v;

  // Instruction memory contents: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_1234;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check the bus side before the edge,
  // advance the model at the edge, check IF/ID after it.
  task automatic step(input logic r, input logic red, input logic st,
                      input logic rdy, input logic [31:0] npc);
    logic        exp_req;
    logic [31:0] tgt;
    reset    = r;
    redirect = red;
    stall    = st;
    NPC      = npc;
    bus.imem_ready = rdy;
    #1;
    bus.imem_rdata = rdy ? mem_word(bus.imem_addr) : $urandom();
    exp_req = !r && !m_parked;
    if (r || m_known) begin
      chk("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
    end
    if (m_known) begin
      if (exp_req) begin
        chk("imem_addr", bus.imem_addr, m_stale_busy ? m_stale_addr : m_pc);
      end
      chk("PC", PC, m_pc);
      chk("PC_plus_4", PC_plus_4, m_pc + 32'd4);
    end
    @(posedge clk);
    tgt = {npc[31:2], 2'b00};
    if (r) begin
      m_known = 1'b1; m_pc = RESET_PC; m_parked = 1'b0; m_stale_busy = 1'b0;
      m_ir = NOP_INSTR; m_pcd = 32'd0; m_pc4d = 32'd0; m_v = 1'b0;
    end else if (m_parked) begin
      if (red) begin
        m_parked = 1'b0; m_pc = tgt; m_v = 1'b0;
      end else if (!st) begin
        m_ir = m_park_instr; m_pcd = m_park_pc; m_pc4d = m_park_pc + 32'd4; m_v = 1'b1;
        m_pc = m_pc + 32'd4; m_parked = 1'b0;
      end
    end else if (m_stale_busy) begin
      if (red) begin
        m_pc = tgt; m_v = 1'b0;
      end else begin
        if (rdy) m_stale_busy = 1'b0;
        if (!st) m_v = 1'b0;
      end
    end else if (rdy) begin
      if (red) begin
        m_pc = tgt; m_v = 1'b0;
      end else if (st) begin
        m_parked = 1'b1; m_park_instr = mem_word(m_pc); m_park_pc = m_pc;
      end else begin
        m_ir = mem_word(m_pc); m_pcd = m_pc; m_pc4d = m_pc + 32'd4; m_v = 1'b1;
        m_pc = m_pc + 32'd4;
      end
    end else begin
      if (red) begin
        m_stale_busy = 1'b1; m_stale_addr = m_pc; m_pc = tgt; m_v = 1'b0;
      end else if (!st) begin
        m_v = 1'b0;
      end
    end
    #1;
    if (m_known) begin
      chk("PC_after", PC, m_pc);
      chk("IR_D", IR_D, m_ir);
      chk("PC_D", PC_D, m_pcd);
      chk("PC_plus_4_D", PC_plus_4_D, m_pc4d);
      chk("valid_D", {31'd0, valid_D}, {31'd0, m_v});
    end
  endtask

  initial begin
    m_known = 1'b0;
    m_parked = 1'b0;
    m_stale_busy = 1'b0;
    reset = 1'b1; redirect = 1'b0; stall = 1'b0; NPC = 32'd0;
    bus.imem_ready = 1'b0; bus.imem_rdata = 32'd0;
    @(posedge clk); #1;

    // Reset, then zero-wait streaming.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0);
    chk("reset_pc", PC, 32'h0000_3000);
    chk("reset_valid", {31'd0, valid_D}, 32'd0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    chk("stream_pcd", PC_D, 32'h0000_3008);
    chk("stream_pc4d", PC_plus_4_D, 32'h0000_300C);

    // Stall on the cycle 0x3004 completes, held three cycles.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 1, 0);
    step(0, 0, 1, 0, 0);
    chk("hold_ir_kept", IR_D, mem_word(32'h0000_3000));
    step(0, 0, 0, 1, 0);
    chk("hold_ir", IR_D, mem_word(32'h0000_3004));
    chk("hold_pc", PC, 32'h0000_3008);

    // Redirect in the same cycle 0x3008 completes.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 1, 32'h0000_3100);
    chk("redir_valid", {31'd0, valid_D}, 32'd0);
    step(0, 0, 0, 1, 0);
    chk("redir_target", PC_D, 32'h0000_3100);

    // Redirect while 0x3004 waits two cycles.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 32'h0000_3100);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Redirect beats stall; alignment; PC wrap.
    step(0, 1, 1, 1, 32'h0000_3200);
    chk("rs_pc", PC, 32'h0000_3200);
    step(0, 1, 0, 1, 32'h0000_3203);
    chk("align_pc", PC, 32'h0000_3200);
    step(0, 1, 0, 1, 32'hFFFF_FFFF);
    chk("wrap_pc4", PC_plus_4, 32'h0000_0000);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Reset in SQUASH with the stale request outstanding.
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 1, 0, 0, 32'h0000_3400);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0);
    step(0, 0, 0, 1, 0);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [31:0] npc_r;
      npc_r = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFE : $urandom();
      step($urandom_range(0, 99) < 2, $urandom_range(0, 9) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, 9) < 6, npc_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
